alu_arbiter: RTL and testbench
==============================

// Module: alu_arbiter
// PURPOSE
//  Shares the single sequential ALU (add/sub/mul/div, serial operand load on inbus) between two
//  requesters. Round-robin arbitrates, sequences the ALU protocol (ALU reset pulse, start, M/Q load,
//  wait finish, capture 1 or 2 result words), returns a tagged response. Watchdog aborts hung ops.
// PARAMETERS
//  W        16   data width of ALU buses and operands
//  TIMEOUT  255  max cycles in WAIT before abort; 8-bit counter
// PORTS
//  clk          in   1   clock, all logic on posedge
//  rst_b        in   1   synchronous, ACTIVE-HIGH reset (polarity fixed for this block)
//  req0/req1    in   1   request; held high with op/a/b stable until matching gnt
//  op0/op1      in   2   00 add, 01 sub, 10 mul, 11 div
//  a0/a1        in   W   operand A
//  b0/b1        in   W   operand B
//  gnt0/gnt1    out  1   1-cycle pulse: operands latched, requester may drop req
//  rsp_valid    out  1   1-cycle pulse: response fields valid
//  rsp_id       out  1   requester served (0/1)
//  rsp_hi       out  W   mul: product[2W-1:W]; div: remainder; add/sub: 0
//  rsp_lo       out  W   mul: product[W-1:0]; div: quotient; add/sub: result
//  rsp_ovf      out  1   ALU overflow for add/sub; 0 for mul/div
//  rsp_err      out  1   watchdog abort; hi/lo/ovf = 0 when set
//  alu_rst_b    out  1   ALU reset, active-low
//  alu_start    out  1   ALU start
//  alu_s        out  2   ALU op select
//  alu_inbus    out  W   ALU operand input
//  alu_outbus   in   W   ALU result output
//  alu_finish   in   1   ALU done
//  alu_overflow in   1   ALU overflow flag
// BEHAVIOUR
//  Reset (rst_b=1, sampled at posedge): state IDLE, rr pointer=0, gnt*/rsp_*=0, alu_start=0,
//   alu_s=0, alu_inbus=0, alu_rst_b=0 (ALU held in reset while rst_b high). Mid-op reset: op dropped, no rsp.
//  ALU contract: first loaded word = M, second = Q; sub gives Q-M, div gives Q/M (rem, quot).
//   Controller sends B first, A second => results are A-B, A/B. mul/div: hi word on outbus in the
//   alu_finish cycle, lo word on the next cycle; add/sub: single word in finish cycle.
//  FSM (one state per cycle unless noted):
//   IDLE  : any req -> ARB. Both req: grant id != last served (pointer); pointer toggles on grant.
//   ARB   : gntX=1, latch op/a/b/id -> ARST.
//   ARST  : alu_rst_b=0, alu_s=op -> LDM.
//   LDM   : alu_rst_b=1, alu_start=1, alu_inbus=B -> LDQ.
//   LDQ   : alu_start=0, alu_inbus=A, clear watchdog -> WAIT.
//   WAIT  : on alu_finish: capture word, ovf (add/sub) -> mul/div ? CAPLO : RESP.
//           cnt==TIMEOUT w/o finish -> ABORT. cnt increments otherwise.
//   CAPLO : capture lo word -> RESP.
//   RESP  : rsp_valid=1 with fields -> IDLE.
//   ABORT : rsp_valid=1, rsp_err=1, alu_rst_b=0 -> IDLE.
//  Requests arriving during an op wait in IDLE; no queueing beyond req hold. Latency add/sub =
//   ALU latency + 5 cycles req->rsp_valid; mul/div +1. rsp_* fields hold until next rsp_valid.
//  Overflow: only add/sub pass alu_overflow; mul/div force 0. alu_finish outside WAIT is ignored.
// STRUCTURE
//  alu_ctrl_pkg: OP_ADD/OP_SUB/OP_MUL/OP_DIV codes, state enum localparams, TIMEOUT width.
//  Sub-module rr_arb2: 2-way round-robin arbiter (req0/req1, advance -> one-hot grant, pointer).
// TESTING (bench includes ALU model or real ALU)
//  1 req0 add a=2147 b=5 -> gnt0 pulse, rsp_id=0, rsp_lo=0x0868, rsp_hi=0, rsp_ovf=0.
//  2 req0 add a=16389 b=16386 -> rsp_lo=0x8007, rsp_ovf=1; req1 sub a=0x8000 b=1 -> rsp_lo=0x7FFF, ovf=1.
//  3 req1 mul a=2147 b=5 -> rsp_hi=0x0000, rsp_lo=0x29EF, ovf=0; div a=2147 b=5 -> hi=2, lo=0x01AD.
//  4 req0+req1 asserted same cycle, both held -> gnt0 then gnt1 (ptr=0), rsp_id 0 then 1; repeat -> gnt1 first.
//  5 ALU model never raises finish -> rsp_err=1 after TIMEOUT+1 WAIT cycles, alu_rst_b low 1 cycle, next req served.
//  6 rst_b=1 during WAIT of mul -> no rsp_valid, all outputs at reset values next cycle, fresh add completes.

Source files
------------

// File: rtl/alu_ctrl_pkg.sv
// Shared encodings for the ALU arbiter: operation codes, controller states, watchdog width.
package alu_ctrl_pkg;

  localparam int TMO_W = 8;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_DIV = 2'b11
  } op_e;

  typedef enum logic [3:0] {
    S_IDLE,
    S_ARB,
    S_ARST,
    S_LDM,
    S_LDQ,
    S_WAIT,
    S_CAPLO,
    S_RESP,
    S_ABORT
  } state_e;

  // mul/div return two result words (hi in the finish cycle, lo in the next)
  function automatic logic is_wide(op_e op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Bundles the two requester ports, the response port and the sequential-ALU port.
interface alu_arbiter_if #(
  parameter int W = 16
);
  logic         req0, req1;
  logic [1:0]   op0, op1;
  logic [W-1:0] a0, a1, b0, b1;
  logic         gnt0, gnt1;
  logic         rsp_valid, rsp_id;
  logic [W-1:0] rsp_hi, rsp_lo;
  logic         rsp_ovf, rsp_err;
  logic         alu_rst_b, alu_start;
  logic [1:0]   alu_s;
  logic [W-1:0] alu_inbus, alu_outbus;
  logic         alu_finish, alu_overflow;

  modport slave (
    input  req0, req1, op0, op1, a0, a1, b0, b1,
    input  alu_outbus, alu_finish, alu_overflow,
    output gnt0, gnt1, rsp_valid, rsp_id, rsp_hi, rsp_lo, rsp_ovf, rsp_err,
    output alu_rst_b, alu_start, alu_s, alu_inbus
  );

  modport master (
    output req0, req1, op0, op1, a0, a1, b0, b1,
    output alu_outbus, alu_finish, alu_overflow,
    input  gnt0, gnt1, rsp_valid, rsp_id, rsp_hi, rsp_lo, rsp_ovf, rsp_err,
    input  alu_rst_b, alu_start, alu_s, alu_inbus
  );
endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: a lone request always wins; on contention the
// priority pointer decides and then flips so the other side wins next contention.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_b,
  input  logic       req0,
  input  logic       req1,
  input  logic       advance,
  output logic [1:0] grant
);

  logic ptr_q, ptr_d;

  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    grant = {req1, req0};
    if (req0 && req1) grant = ptr_q ? 2'b10 : 2'b01;
  end

  assign ptr_d = (advance && req0 && req1) ? ~ptr_q : ptr_q;

  // NOTE: registers are updated with non-blocking assignments so all flops sample together.
  always_ff @(posedge clk) begin
    if (rst_b) ptr_q <= 1'b0;
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one sequential ALU between two requesters: arbitrates, runs the ALU
// load/start/finish protocol, returns a tagged response, aborts hung operations.
module alu_arbiter
  import alu_ctrl_pkg::*;
#(
  parameter int W       = 16,
  parameter int TIMEOUT = 255
) (
  input logic          clk,
  input logic          rst_b,
  alu_arbiter_if.slave bus
);

  state_e             state_q, state_d;
  logic               id_q;
  op_e                op_q;
  logic [W-1:0]       a_q, b_q;
  logic [W-1:0]       hi_q, hi_d;
  logic [TMO_W-1:0]   cnt_q, cnt_d;
  logic               rsp_id_q, rsp_id_d;
  logic [W-1:0]       rsp_hi_q, rsp_hi_d, rsp_lo_q, rsp_lo_d;
  logic               rsp_ovf_q, rsp_ovf_d, rsp_err_q, rsp_err_d;

  logic               adv;
  logic [1:0]         grant;
  logic [1:0]         gnt_c;
  logic               rsp_valid_c, alu_start_c, alu_rst_c;
  logic [W-1:0]       alu_inbus_c;

  rr_arb2 u_arb (
    .clk     (clk),
    .rst_b   (rst_b),
    .req0    (bus.req0),
    .req1    (bus.req1),
    .advance (adv),
    .grant   (grant)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    hi_d        = hi_q;
    rsp_id_d    = rsp_id_q;
    rsp_hi_d    = rsp_hi_q;
    rsp_lo_d    = rsp_lo_q;
    rsp_ovf_d   = rsp_ovf_q;
    rsp_err_d   = rsp_err_q;
    adv         = 1'b0;
    gnt_c       = 2'b00;
    rsp_valid_c = 1'b0;
    alu_start_c = 1'b0;
    alu_rst_c   = 1'b1;
    alu_inbus_c = '0;

    case (state_q)
      S_IDLE: begin
        if (bus.req0 || bus.req1) begin
          adv     = 1'b1;
          state_d = S_ARB;
        end
      end
      S_ARB: begin
        gnt_c   = id_q ? 2'b10 : 2'b01;
        state_d = S_ARST;
      end
      S_ARST: begin
        alu_rst_c = 1'b0;
        state_d   = S_LDM;
      end
      // B goes in first as M, A second as Q, so the ALU yields A-B and A/B
      S_LDM: begin
        alu_start_c = 1'b1;
        alu_inbus_c = b_q;
        state_d     = S_LDQ;
      end
      S_LDQ: begin
        alu_inbus_c = a_q;
        cnt_d       = '0;
        state_d     = S_WAIT;
      end
      S_WAIT: begin
        if (bus.alu_finish) begin
          if (is_wide(op_q)) begin
            hi_d    = bus.alu_outbus;
            state_d = S_CAPLO;
          end else begin
            rsp_id_d  = id_q;
            rsp_hi_d  = '0;
            rsp_lo_d  = bus.alu_outbus;
            rsp_ovf_d = bus.alu_overflow;
            rsp_err_d = 1'b0;
            state_d   = S_RESP;
          end
        end else if (cnt_q == TMO_W'(TIMEOUT)) begin
          rsp_id_d  = id_q;
          rsp_hi_d  = '0;
          rsp_lo_d  = '0;
          rsp_ovf_d = 1'b0;
          rsp_err_d = 1'b1;
          state_d   = S_ABORT;
        end else begin
          cnt_d = cnt_q + TMO_W'(1);
        end
      end
      S_CAPLO: begin
        rsp_id_d  = id_q;
        rsp_hi_d  = hi_q;
        rsp_lo_d  = bus.alu_outbus;
        rsp_ovf_d = 1'b0;
        rsp_err_d = 1'b0;
        state_d   = S_RESP;
      end
      S_RESP: begin
        rsp_valid_c = 1'b1;
        state_d     = S_IDLE;
      end
      S_ABORT: begin
        rsp_valid_c = 1'b1;
        alu_rst_c   = 1'b0;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_b) begin
      state_q   <= S_IDLE;
      id_q      <= 1'b0;
      op_q      <= OP_ADD;
      a_q       <= '0;
      b_q       <= '0;
      hi_q      <= '0;
      cnt_q     <= '0;
      rsp_id_q  <= 1'b0;
      rsp_hi_q  <= '0;
      rsp_lo_q  <= '0;
      rsp_ovf_q <= 1'b0;
      rsp_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      rsp_id_q  <= rsp_id_d;
      rsp_hi_q  <= rsp_hi_d;
      rsp_lo_q  <= rsp_lo_d;
      rsp_ovf_q <= rsp_ovf_d;
      rsp_err_q <= rsp_err_d;
      if (adv) id_q <= grant[1];
      if (state_q == S_ARB) begin
        op_q <= op_e'(id_q ? bus.op1 : bus.op0);
        a_q  <= id_q ? bus.a1 : bus.a0;
        b_q  <= id_q ? bus.b1 : bus.b0;
      end
    end
  end

  // Strobes are masked while reset is asserted so a mid-op reset never leaks a pulse.
  assign bus.gnt0      = gnt_c[0] & ~rst_b;
  assign bus.gnt1      = gnt_c[1] & ~rst_b;
  assign bus.rsp_valid = rsp_valid_c & ~rst_b;
  assign bus.alu_start = alu_start_c & ~rst_b;
  assign bus.alu_rst_b = alu_rst_c & ~rst_b;
  assign bus.alu_inbus = rst_b ? '0 : alu_inbus_c;
  assign bus.alu_s     = op_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_hi    = rsp_hi_q;
  assign bus.rsp_lo    = rsp_lo_q;
  assign bus.rsp_ovf   = rsp_ovf_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: behavioural sequential-ALU stand-in plus
// an arithmetic reference model and a round-robin order model.
module tb_alu_arbiter;
  import alu_ctrl_pkg::*;

  localparam int W       = 16;
  localparam int TIMEOUT = 255;

  logic clk   = 1'b0;
  logic rst_b = 1'b1;
  always #5 clk = ~clk;

  alu_arbiter_if #(.W(W)) bus ();

  alu_arbiter #(.W(W), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .rst_b (rst_b),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- sequential ALU stand-in (M first, Q second) ----------------
  int           alu_lat  = 2;
  bit           alu_hang = 1'b0;
  int           ph = 0;
  int           lat_cnt = 0;
  logic [W-1:0] m_r, q_r, res_hi, res_lo;
  logic [W:0]   tmp;
  logic         res_ovf;
  logic [1:0]   s_r;

  always @(posedge clk) begin
    if (bus.alu_rst_b !== 1'b1) begin
      ph = 0;
      bus.alu_finish   <= 1'b0;
      bus.alu_outbus   <= '0;
      bus.alu_overflow <= 1'b0;
    end else begin
      case (ph)
        0: begin
          bus.alu_finish <= 1'b0;
          if (bus.alu_start === 1'b1) begin
            m_r = bus.alu_inbus;
            s_r = bus.alu_s;
            ph  = 1;
          end
        end
        1: begin
          q_r     = bus.alu_inbus;
          res_hi  = '0;
          res_ovf = 1'b0;
          case (s_r)
            2'b00: begin
              tmp = {1'b0, q_r} + {1'b0, m_r};
              res_lo  = tmp[W-1:0];
              res_ovf = (q_r[W-1] == m_r[W-1]) && (res_lo[W-1] != q_r[W-1]);
            end
            2'b01: begin
              res_lo  = q_r - m_r;
              res_ovf = (q_r[W-1] != m_r[W-1]) && (res_lo[W-1] != q_r[W-1]);
            end
            2'b10: {res_hi, res_lo} = q_r * m_r;
            default: begin
              res_hi = (m_r == 0) ? q_r : q_r % m_r;
              res_lo = (m_r == 0) ? '1  : q_r / m_r;
            end
          endcase
          lat_cnt = alu_lat;
          ph      = 2;
        end
        2: begin
          if (!alu_hang) begin
            if (lat_cnt == 0) begin
              bus.alu_finish   <= 1'b1;
              bus.alu_outbus   <= s_r[1] ? res_hi : res_lo;
              bus.alu_overflow <= res_ovf;
              ph = s_r[1] ? 3 : 4;
            end else begin
              lat_cnt--;
            end
          end
        end
        3: begin
          bus.alu_finish <= 1'b0;
          bus.alu_outbus <= res_lo;
          ph = 0;
        end
        default: begin
          bus.alu_finish <= 1'b0;
          ph = 0;
        end
      endcase
    end
  end

  // ---------------- reference model ----------------
  function automatic void ref_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                 output logic [W-1:0] hi, output logic [W-1:0] lo, output logic ovf);
    int     sa, sb, r;
    longint p;
    sa  = $signed(a);
    sb  = $signed(b);
    hi  = '0;
    lo  = '0;
    ovf = 1'b0;
    case (op)
      OP_ADD: begin r = sa + sb; lo = W'(r); ovf = (r > 32767) || (r < -32768); end
      OP_SUB: begin r = sa - sb; lo = W'(r); ovf = (r > 32767) || (r < -32768); end
      OP_MUL: begin p = longint'(a) * longint'(b); hi = W'(p >> W); lo = W'(p); end
      default: begin hi = a % b; lo = a / b; end
    endcase
  endfunction

  logic [1:0]   t_op[2];
  logic [W-1:0] t_a[2];
  logic [W-1:0] t_b[2];
  int           prio_m = 0;

  task automatic set_req(input int id, input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    t_op[id] = op;
    t_a[id]  = a;
    t_b[id]  = b;
  endtask

  // Raise the requested lines together and follow both grants and responses.
  task automatic serve(input logic [1:0] want, input string tag);
    int           order[$];
    int           cyc, gi, ri, id, last_gnt, exp_lat;
    logic [W-1:0] ehi, elo;
    logic         eovf;
    elo = '0;
    if (want == 2'b11) begin
      order.push_back(prio_m);
      order.push_back(1 - prio_m);
      prio_m = 1 - prio_m;
    end else begin
      order.push_back(want[1] ? 1 : 0);
    end
    @(negedge clk);
    bus.op0 = t_op[0]; bus.a0 = t_a[0]; bus.b0 = t_b[0];
    bus.op1 = t_op[1]; bus.a1 = t_a[1]; bus.b1 = t_b[1];
    bus.req0 = want[0];
    bus.req1 = want[1];
    cyc = 0; gi = 0; ri = 0; last_gnt = 0;
    while (ri < order.size() && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (bus.gnt0 || bus.gnt1) begin
        check({tag, ":gnt_onehot"}, 32'(bus.gnt0 & bus.gnt1), 32'd0);
        if (gi < order.size()) check({tag, ":gnt_id"}, 32'(bus.gnt1), 32'(order[gi]));
        else                   check({tag, ":extra_gnt"}, 32'd1, 32'd0);
        if (gi == 0) check({tag, ":gnt_lat"}, 32'(cyc), 32'd1);
        last_gnt = cyc;
        if (bus.gnt0) bus.req0 = 1'b0;
        if (bus.gnt1) bus.req1 = 1'b0;
        gi++;
      end
      if (bus.rsp_valid) begin
        id = order[ri];
        if (alu_hang) begin
          ehi = '0; elo = '0; eovf = 1'b0;
          exp_lat = TIMEOUT + 5;
          check({tag, ":abort_alu_rst"}, 32'(bus.alu_rst_b), 32'd0);
        end else begin
          ref_op(t_op[id], t_a[id], t_b[id], ehi, elo, eovf);
          exp_lat = alu_lat + 6 + (t_op[id][1] ? 1 : 0);
        end
        check({tag, ":rsp_id"},  32'(bus.rsp_id),  32'(id));
        check({tag, ":rsp_hi"},  32'(bus.rsp_hi),  32'(ehi));
        check({tag, ":rsp_lo"},  32'(bus.rsp_lo),  32'(elo));
        check({tag, ":rsp_ovf"}, 32'(bus.rsp_ovf), 32'(eovf));
        check({tag, ":rsp_err"}, 32'(bus.rsp_err), 32'(alu_hang));
        check({tag, ":rsp_lat"}, 32'(cyc - last_gnt), 32'(exp_lat));
        ri++;
      end
    end
    if (ri < order.size()) check({tag, ":timeout"}, 32'd1, 32'd0);
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    @(negedge clk);
    check({tag, ":rsp_pulse"}, 32'(bus.rsp_valid), 32'd0);
    check({tag, ":rsp_hold"},  32'(bus.rsp_lo),    32'(elo));
    if (alu_hang) check({tag, ":alu_rst_release"}, 32'(bus.alu_rst_b), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ":gnt0"},      32'(bus.gnt0),      32'd0);
    check({tag, ":gnt1"},      32'(bus.gnt1),      32'd0);
    check({tag, ":rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
    check({tag, ":rsp_lo"},    32'(bus.rsp_lo),    32'd0);
    check({tag, ":rsp_hi"},    32'(bus.rsp_hi),    32'd0);
    check({tag, ":rsp_id"},    32'(bus.rsp_id),    32'd0);
    check({tag, ":alu_start"}, 32'(bus.alu_start), 32'd0);
    check({tag, ":alu_s"},     32'(bus.alu_s),     32'd0);
    check({tag, ":alu_inbus"}, 32'(bus.alu_inbus), 32'd0);
    check({tag, ":alu_rst_b"}, 32'(bus.alu_rst_b), 32'd0);
  endtask

  initial begin
    int           cyc, pulses;
    logic [1:0]   want;
    logic [1:0]   rop;
    logic [W-1:0] rb;
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    bus.op0 = '0; bus.op1 = '0;
    bus.a0 = '0; bus.a1 = '0; bus.b0 = '0; bus.b1 = '0;
    rst_b = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    rst_b = 1'b0;

    set_req(0, OP_ADD, 16'd2147, 16'd5);     serve(2'b01, "t1_add");
    set_req(0, OP_ADD, 16'd16389, 16'd16386); serve(2'b01, "t2_add_ovf");
    set_req(1, OP_SUB, 16'h8000, 16'd1);     serve(2'b10, "t2_sub_ovf");
    set_req(1, OP_MUL, 16'd2147, 16'd5);     serve(2'b10, "t3_mul");
    set_req(1, OP_DIV, 16'd2147, 16'd5);     serve(2'b10, "t3_div");

    set_req(0, OP_ADD, 16'd100, 16'd23);
    set_req(1, OP_MUL, 16'd300, 16'd400);
    serve(2'b11, "t4_pair_a");
    serve(2'b11, "t4_pair_b");

    alu_hang = 1'b1;
    set_req(0, OP_ADD, 16'd1, 16'd2);        serve(2'b01, "t5_hang");
    alu_hang = 1'b0;
    set_req(1, OP_SUB, 16'd50, 16'd8);       serve(2'b10, "t5_after");

    // Reset in the middle of a multiply's WAIT phase
    alu_lat = 30;
    set_req(1, OP_MUL, 16'd1234, 16'd567);
    @(negedge clk);
    bus.op1 = t_op[1]; bus.a1 = t_a[1]; bus.b1 = t_b[1];
    bus.req1 = 1'b1;
    cyc = 0;
    while (!bus.gnt1 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check("t6:gnt_seen", 32'(bus.gnt1), 32'd1);
    bus.req1 = 1'b0;
    repeat (6) @(negedge clk);
    rst_b = 1'b1;
    @(negedge clk);
    check_reset_outputs("t6_reset");
    @(negedge clk);
    rst_b = 1'b0;
    prio_m = 0;
    pulses = 0;
    repeat (50) begin
      @(negedge clk);
      if (bus.rsp_valid) pulses++;
    end
    check("t6:no_rsp", 32'(pulses), 32'd0);
    alu_lat = 1;
    set_req(0, OP_ADD, 16'd7, 16'd9);        serve(2'b01, "t6_fresh");

    for (int i = 0; i < 40; i++) begin
      alu_lat = $urandom_range(0, 5);
      want    = 2'($urandom_range(1, 3));
      for (int k = 0; k < 2; k++) begin
        rop = 2'($urandom_range(0, 3));
        rb  = 16'($urandom);
        if (rop == OP_DIV && rb == 0) rb = 16'd3;
        set_req(k, rop, 16'($urandom), rb);
      end
      serve(want, $sformatf("rnd%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
